// File: rtl/eclk_div_align.sv
// Edge-clock divider after the ECLK sync/gate: divides by DIV, gates cleanly on STOP at the
// slow-period boundary, and swallows one edge per ALIGNWD rise with a DIV-edge lockout.
module eclk_div_align #(
   parameter int DIV         = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic       ECLKIN,
   input  logic       DIVRST,
   input  logic       STOP,
   input  logic       ALIGNWD,
   output logic       DIVOUT,
   output logic       ECLKEN,
   output logic [2:0] PHASE,
   output logic [3:0] SLIPCNT,
   output logic       ALIGNBUSY
);

   generate
      if (!(DIV == 2 || DIV == 4 || DIV == 5)) begin : g_bad_div
         $error("eclk_div_align: DIV must be 2, 4 or 5");
      end
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("eclk_div_align: SYNC_STAGES must be >= 2");
      end
   endgenerate

   localparam logic [2:0] LAST      = 3'(DIV - 1);
   localparam logic [2:0] HIGH      = 3'((DIV + 1) / 2);
   localparam logic [2:0] LOCK_INIT = 3'(DIV);

   localparam logic [0:0] ST_STOPPED = 1'b0;
   localparam logic [0:0] ST_RUN     = 1'b1;

   logic [SYNC_STAGES-1:0] stop_sync;
   logic [SYNC_STAGES-1:0] align_sync;
   logic                   align_d;
   logic                   stop_s;
   logic                   align_s;
   logic                   slip_req;
   logic [0:0]             state;
   logic [2:0]             lock_cnt;
   logic [2:0]             lock_dec;

   assign stop_s   = stop_sync[SYNC_STAGES-1];
   assign align_s  = align_sync[SYNC_STAGES-1];
   assign slip_req = align_s & ~align_d;
   assign lock_dec = (lock_cnt != 3'd0) ? lock_cnt - 3'd1 : 3'd0;

   always_ff @(posedge ECLKIN or posedge DIVRST) begin
      if (DIVRST) begin
         stop_sync  <= '0;
         align_sync <= '0;
         align_d    <= 1'b0;
      end else begin
         stop_sync  <= {stop_sync[SYNC_STAGES-2:0], STOP};
         align_sync <= {align_sync[SYNC_STAGES-2:0], ALIGNWD};
         align_d    <= align_s;
      end
   end

   always_ff @(posedge ECLKIN or posedge DIVRST) begin
      if (DIVRST) begin
         state     <= ST_STOPPED;
         PHASE     <= 3'd0;
         DIVOUT    <= 1'b0;
         ECLKEN    <= 1'b0;
         SLIPCNT   <= 4'd0;
         ALIGNBUSY <= 1'b0;
         lock_cnt  <= 3'd0;
      end else begin
         // Lockout runs down in both states; a slip edge below reloads it.
         lock_cnt  <= lock_dec;
         ALIGNBUSY <= (lock_dec != 3'd0);
         case (state)
            ST_STOPPED: begin
               PHASE  <= 3'd0;
               DIVOUT <= 1'b0;
               if (!stop_s) begin
                  state  <= ST_RUN;
                  ECLKEN <= 1'b1;
               end else begin
                  ECLKEN <= 1'b0;
               end
            end
            default: begin
               if (stop_s && PHASE == LAST) begin
                  state  <= ST_STOPPED;
                  ECLKEN <= 1'b0;
                  PHASE  <= 3'd0;
                  DIVOUT <= 1'b0;
               end else if (!stop_s && slip_req && !ALIGNBUSY) begin
                  // Swallow this edge: PHASE and DIVOUT hold.
                  SLIPCNT   <= SLIPCNT + 4'd1;
                  lock_cnt  <= LOCK_INIT;
                  ALIGNBUSY <= 1'b1;
               end else begin
                  DIVOUT <= (PHASE < HIGH);
                  PHASE  <= (PHASE == LAST) ? 3'd0 : PHASE + 3'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eclk_div_align.sv
// Scoreboard bench for eclk_div_align: per-edge expectations are queued as stimulus is driven
// and popped/compared shortly after each rising ECLKIN edge.
module tb_eclk_div_align;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, stop, alignwd;

   logic       div4, en4, bz4;
   logic [2:0] ph4;
   logic [3:0] sc4;
   logic       div5, en5, bz5;
   logic [2:0] ph5;
   logic [3:0] sc5;
   logic       div2, en2, bz2;
   logic [2:0] ph2;
   logic [3:0] sc2;

   eclk_div_align #(.DIV(4), .SYNC_STAGES(2)) u4 (
      .ECLKIN(clk), .DIVRST(rst), .STOP(stop), .ALIGNWD(alignwd),
      .DIVOUT(div4), .ECLKEN(en4), .PHASE(ph4), .SLIPCNT(sc4), .ALIGNBUSY(bz4));
   eclk_div_align #(.DIV(5), .SYNC_STAGES(2)) u5 (
      .ECLKIN(clk), .DIVRST(rst), .STOP(stop), .ALIGNWD(alignwd),
      .DIVOUT(div5), .ECLKEN(en5), .PHASE(ph5), .SLIPCNT(sc5), .ALIGNBUSY(bz5));
   eclk_div_align #(.DIV(2), .SYNC_STAGES(2)) u2 (
      .ECLKIN(clk), .DIVRST(rst), .STOP(stop), .ALIGNWD(alignwd),
      .DIVOUT(div2), .ECLKEN(en2), .PHASE(ph2), .SLIPCNT(sc2), .ALIGNBUSY(bz2));

   // -1 in any field means "not checked on this edge".
   typedef struct {
      int p4, d4, en, sc, bz, p5, d5, p2, d2;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   edge_no  = 0;

   // Start-up pattern for edges 2..9 after reset release.
   int p4a[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
   int d4a[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
   int p5a[8] = '{1, 2, 3, 4, 0, 1, 2, 3};
   int d5a[8] = '{1, 1, 1, 0, 0, 1, 1, 1};
   int p2a[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
   int d2a[8] = '{1, 0, 1, 0, 1, 0, 1, 0};

   task automatic check_val(input string tag, input int act, input int expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, expv);
      end
   endtask

   task automatic cmp_opt(input string tag, input int act, input int expv);
      if (expv != -1) check_val(tag, act, expv);
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #2;
      edge_no++;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         cmp_opt($sformatf("t%0d_phase4", edge_no), int'(ph4), e.p4);
         cmp_opt($sformatf("t%0d_divout4", edge_no), int'(div4), e.d4);
         cmp_opt($sformatf("t%0d_eclken4", edge_no), int'(en4), e.en);
         cmp_opt($sformatf("t%0d_slipcnt4", edge_no), int'(sc4), e.sc);
         cmp_opt($sformatf("t%0d_alignbusy4", edge_no), int'(bz4), e.bz);
         cmp_opt($sformatf("t%0d_phase5", edge_no), int'(ph5), e.p5);
         cmp_opt($sformatf("t%0d_divout5", edge_no), int'(div5), e.d5);
         cmp_opt($sformatf("t%0d_phase2", edge_no), int'(ph2), e.p2);
         cmp_opt($sformatf("t%0d_divout2", edge_no), int'(div2), e.d2);
      end
   end

   // Called at a falling edge: inputs already set apply to the next rising edge.
   task automatic step_all(input int p4, input int d4, input int en, input int sc, input int bz,
                           input int p5, input int d5, input int p2, input int d2);
      exp_t e;
      e = '{p4, d4, en, sc, bz, p5, d5, p2, d2};
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic step(input int p4, input int d4, input int en, input int sc, input int bz);
      step_all(p4, d4, en, sc, bz, -1, -1, -1, -1);
   endtask

   task automatic dc();
      step_all(-1, -1, -1, -1, -1, -1, -1, -1, -1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst     = 1'b1;
      stop    = 1'b0;
      alignwd = 1'b0;
      @(negedge clk);
      repeat (2) step_all(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Start-up and divide patterns for DIV=4, 5, 2.
      rst = 1'b0;
      step_all(0, 0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++)
         step_all(p4a[i], d4a[i], 1, 0, 0, p5a[i], d5a[i], p2a[i], d2a[i]);

      // Stop raised with PHASE=1: runs to the boundary, then gates.
      step(1, 1, 1, 0, 0);
      stop = 1'b1;
      step(2, 1, 1, 0, 0);
      step(3, 0, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      stop = 1'b0;
      repeat (2) step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      step(2, 1, 1, 0, 0);
      step(3, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);

      // Slip, then a second rise inside the lockout is dropped.
      alignwd = 1'b1;
      step(1, 1, 1, 0, 0);
      step(2, 1, 1, 0, 0);
      step(2, 1, 1, 1, 1);
      alignwd = 1'b0;
      step(3, 0, 1, 1, 1);
      alignwd = 1'b1;
      step(0, 0, 1, 1, 1);
      step(1, 1, 1, 1, 1);
      step(2, 1, 1, 1, 0);
      step(3, 0, 1, 1, 0);

      // Slip request lands on the stop boundary edge: stop wins.
      alignwd = 1'b0;
      step(0, 0, 1, 1, 0);
      step(1, 1, 1, 1, 0);
      stop    = 1'b1;
      alignwd = 1'b1;
      step(2, 1, 1, 1, 0);
      step(3, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0);

      // Slip request while STOPPED is dropped.
      alignwd = 1'b0;
      repeat (2) step(0, 0, 0, 1, 0);
      alignwd = 1'b1;
      repeat (4) step(0, 0, 0, 1, 0);

      // Spaced slips until SLIPCNT wraps back to 0.
      stop = 1'b0;
      repeat (4) dc();
      for (int k = 1; k <= 15; k++) begin
         alignwd = 1'b0;
         repeat (3) dc();
         alignwd = 1'b1;
         repeat (7) dc();
         step(-1, -1, 1, (1 + k) % 16, 0);
      end

      // Async reset in the middle of a lockout with STOP high.
      alignwd = 1'b0;
      repeat (3) dc();
      alignwd = 1'b1;
      repeat (3) dc();
      stop = 1'b1;
      step(-1, -1, 1, 1, 1);
      #2;
      rst = 1'b1;
      #1;
      check_val("arst_divout", int'(div4), 0);
      check_val("arst_eclken", int'(en4), 0);
      check_val("arst_phase", int'(ph4), 0);
      check_val("arst_slipcnt", int'(sc4), 0);
      check_val("arst_alignbusy", int'(bz4), 0);
      alignwd = 1'b0;
      @(negedge clk);
      repeat (2) step(0, 0, 0, 0, 0);
      rst = 1'b0;
      repeat (7) dc();
      repeat (3) step(0, 0, 0, 0, 0);

      @(negedge clk);
      if (sb.size() != 0) check_val("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/eclk_div_align.md
Name: eclk_div_align

Overview:
- Cycle-accurate behavioural model of the edge-clock divider stage that sits directly downstream of the edge-clock sync/gate primitive on LIFCL.
- Divides the gated edge clock by an integer ratio to produce the slow clock.
- Handles the synchronised STOP gating handshake and the ALIGNWD word-alignment slip request.
- Used as the golden reference when checking ECLK primitive fuzzer configurations and timing sims.

Parameters:
- DIV, 4, divide ratio. Legal values are 2, 4 and 5; any other value is an elaboration error.
- SYNC_STAGES, 2, depth of the STOP and ALIGNWD synchronisers. Must be >= 2.

Ports:
- ECLKIN  input  1  edge clock; all state updates on its rising edge
- DIVRST  input  1  asynchronous, active-high reset
- STOP  input  1  asynchronous request to gate the edge clock
- ALIGNWD  input  1  asynchronous slip request; acts on its rising edge
- DIVOUT  output  1  divided slow clock (registered)
- ECLKEN  output  1  edge-clock gate enable (1 = running)
- PHASE  output  3  current divider count, 0..DIV-1
- SLIPCNT  output  4  number of slips performed, wraps 15->0
- ALIGNBUSY  output  1  slip lockout is active

Behaviour:
- Reset: DIVRST=1 asynchronously forces the following, and holds them while asserted:
  - all synchroniser flops = 0
  - state = STOPPED, PHASE = 0, DIVOUT = 0, ECLKEN = 0
  - SLIPCNT = 0, ALIGNBUSY = 0, lockout counter = 0
  - Reset asserted mid-operation aborts everything immediately; no pending slip or stop survives reset.
- Synchronisers:
  - stop_s is the last stage of a SYNC_STAGES flop chain on STOP.
  - align_s is the last stage of a SYNC_STAGES chain on ALIGNWD; align_d is align_s delayed one edge.
  - slip_req = align_s & ~align_d.
  - An input change set up before edge 0 is acted on at edge SYNC_STAGES (edge 2 by default).
- HIGH = ceil(DIV/2). With cnt being PHASE before the edge, on a counting edge:
  - DIVOUT <= (cnt < HIGH)
  - PHASE <= (cnt == DIV-1) ? 0 : cnt+1
- State machine, evaluated on each edge in priority order:
  - STOPPED, stop_s=0: go to RUN, ECLKEN<=1. PHASE and DIVOUT hold at 0; counting starts on the next edge.
  - STOPPED, stop_s=1: hold, with ECLKEN=0, PHASE=0, DIVOUT=0.
  - RUN, stop_s=1 and PHASE==DIV-1: go to STOPPED, ECLKEN<=0, PHASE<=0, DIVOUT<=0. This is the slow-period boundary, so there are no runt DIVOUT pulses.
  - RUN, stop_s=1 and PHASE!=DIV-1: keep counting normally until the boundary.
  - RUN, slip_req=1 and ALIGNBUSY=0: the slip edge.
    - PHASE and DIVOUT hold (one ECLK cycle is swallowed).
    - SLIPCNT <= SLIPCNT+1, wrapping mod 16.
    - Lockout counter <= DIV, ALIGNBUSY <= 1.
  - RUN, otherwise: normal count.
- Lockout:
  - The lockout counter decrements by 1 on every edge while nonzero, in both states.
  - ALIGNBUSY <= (next counter value != 0), so it is high for exactly DIV edges after the slip edge.
  - slip_req seen while ALIGNBUSY=1 is dropped, not queued.
- Simultaneous events:
  - The stop boundary edge takes priority over slip_req: the slip is dropped and SLIPCNT is unchanged.
  - slip_req in STOPPED is dropped.
  - A STOP pulse shorter than SYNC_STAGES edges may be missed; this is legal.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset/start, DIV=4: release DIVRST, STOP=0, ALIGNWD=0 -> edge1: ECLKEN=1, PHASE=0, DIVOUT=0. Edges 2..9: DIVOUT = 1,1,0,0,1,1,0,0 and PHASE = 1,2,3,0,1,2,3,0.
- DIV=5 and DIV=2 -> DIVOUT duty is 3 high / 2 low and 1 high / 1 low respectively; PHASE wraps at 4 and at 1.
- Stop mid-period, DIV=4: raise STOP with PHASE=1 -> count continues to PHASE=3; the next edge gives ECLKEN=0, PHASE=0, DIVOUT=0. Drop STOP -> ECLKEN=1 after 2+1 edges, then the pattern restarts 1,1,0,0.
- Slip: ALIGNWD rising edge -> on edge 2 after the rise, PHASE/DIVOUT hold one edge, SLIPCNT 0->1, ALIGNBUSY high for 4 edges. A second ALIGNWD rise during busy -> SLIPCNT stays 1.
- Conflict and wrap:
  - slip_req on the stop boundary edge -> STOPPED, SLIPCNT unchanged.
  - 16 spaced slips -> SLIPCNT wraps to 0.
- Async reset mid-lockout with STOP high -> all outputs 0 immediately. After release with STOP=1, the block stays STOPPED with ECLKEN=0.
